// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel divider, h/v position counters and registered
// sync/blank/frame-start outputs decoded from the next counter values.
module vga_timing_generator #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_START = 144,
    parameter int unsigned H_END   = 783,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_START = 35,
    parameter int unsigned V_END   = 514
) (
    input  logic       clk,
    input  logic       resetN,
    output logic       pixTick,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frameStart
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0]    H_BEG_W  = 10'(H_START);
    localparam logic [9:0]    H_END_W  = 10'(H_END);
    localparam logic [9:0]    V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0]    V_BEG_W  = 10'(V_START);
    localparam logic [9:0]    V_END_W  = 10'(V_END);

    logic [DW-1:0] div;
    logic [DW-1:0] div_n;
    logic [9:0]    h_n;
    logic [9:0]    v_n;
    logic          frame_wrap;
    logic          reset_pending;

    always_comb begin
        div_n      = div + DW'(1);
        h_n        = hCount;
        v_n        = vCount;
        frame_wrap = 1'b0;
        if (div == DIV_LAST) begin
            div_n = '0;
        end
        // both counters wrap on the same edge; (0, V_TOTAL) never exists
        if (pixTick) begin
            if (hCount == H_LAST) begin
                h_n = '0;
                if (vCount == V_LAST) begin
                    v_n        = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_n = vCount + 10'd1;
                end
            end else begin
                h_n = hCount + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            div           <= '0;
            hCount        <= '0;
            vCount        <= '0;
            pixTick       <= 1'b0;
            hSync         <= 1'b0;
            vSync         <= 1'b0;
            bright        <= 1'b0;
            frameStart    <= 1'b0;
            reset_pending <= 1'b1;
        end else begin
            div           <= div_n;
            hCount        <= h_n;
            vCount        <= v_n;
            pixTick       <= (div_n == DIV_LAST);
            hSync         <= !(h_n < H_SYNC_W);
            vSync         <= !(v_n < V_SYNC_W);
            bright        <= (h_n >= H_BEG_W) && (h_n <= H_END_W) &&
                             (v_n >= V_BEG_W) && (v_n <= V_END_W);
            frameStart    <= reset_pending | frame_wrap;
            reset_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: two reduced-geometry instances (divide-by-3 and
// divide-by-1) checked each cycle against an arithmetic raster model.
module tb_vga_timing_generator;

    localparam int HT = 20;
    localparam int HS = 4;
    localparam int HB = 6;
    localparam int HE = 17;
    localparam int VT = 12;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VE = 10;
    localparam int DA = 3;
    localparam int DB = 1;

    typedef struct packed {
        logic       pix;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;

    logic       pix_a, hs_a, vs_a, br_a, fs_a;
    logic [9:0] h_a, v_a;
    logic       pix_b, hs_b, vs_b, br_b, fs_b;
    logic [9:0] h_b, v_b;

    int vectors = 0;
    int miscompares = 0;
    int ka = 0;
    int kb = 0;
    int syncs = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    vga_timing_generator #(
        .CLK_DIV(DA), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HB),
        .H_END(HE), .V_TOTAL(VT), .V_SYNC(VS), .V_START(VB), .V_END(VE)
    ) dut_a (
        .clk(clk), .resetN(resetN), .pixTick(pix_a),
        .hCount(h_a), .vCount(v_a), .hSync(hs_a), .vSync(vs_a),
        .bright(br_a), .frameStart(fs_a)
    );

    vga_timing_generator #(
        .CLK_DIV(DB), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HB),
        .H_END(HE), .V_TOTAL(VT), .V_SYNC(VS), .V_START(VB), .V_END(VE)
    ) dut_b (
        .clk(clk), .resetN(resetN), .pixTick(pix_b),
        .hCount(h_b), .vCount(v_b), .hSync(hs_b), .vSync(vs_b),
        .bright(br_b), .frameStart(fs_b)
    );

    // pixels advanced by the k-th edge after release; pixTick is low
    // through reset, so the first advance needs one tick-high cycle
    function automatic int pixels(input int k, input int d);
        if (k <= 0) return 0;
        return k / d - ((d == 1) ? 1 : 0);
    endfunction

    function automatic bit wraps_at(input int k, input int d);
        int p;
        p = pixels(k, d);
        return (k >= 1) && (p != pixels(k - 1, d)) && (p % (HT * VT) == 0);
    endfunction

    function automatic exp_t model(input int k, input int d);
        exp_t e;
        int p, h, v;
        e = '0;
        if (k == 0) return e;
        p = pixels(k, d);
        h = p % HT;
        v = (p / HT) % VT;
        e.pix = ((k % d) == d - 1);
        e.h = 10'(h);
        e.v = 10'(v);
        e.hs = !(h < HS);
        e.vs = !(v < VS);
        e.br = (h >= HB) && (h <= HE) && (v >= VB) && (v <= VE);
        e.fs = (k == 1) || wraps_at(k, d);
        return e;
    endfunction

    always @(posedge clk) begin
        if (!resetN) begin
            ka = 0;
            kb = 0;
        end else begin
            ka = ka + 1;
            kb = kb + 1;
        end
        qa.push_back(model(ka, DA));
        qb.push_back(model(kb, DB));
    end

    task automatic check(input string name, input exp_t got, input exp_t e);
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t: got pix=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b fs=%0b required pix=%0b h=%0d v=%0d hs=%0b vs=%0b br=%0b fs=%0b",
                     name, $time, got.pix, got.h, got.v, got.hs, got.vs,
                     got.br, got.fs, e.pix, e.h, e.v, e.hs, e.vs, e.br, e.fs);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            check("div3", {pix_a, h_a, v_a, hs_a, vs_a, br_a, fs_a},
                  qa.pop_front());
        end
        if (qb.size() > 0) begin
            check("div1", {pix_b, h_b, v_b, hs_b, vs_b, br_b, fs_b},
                  qb.pop_front());
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        resetN = 1'b0;
        run(n);
        resetN = 1'b1;
    endtask

    // lines the next edge up with a frame wrap of the divide-by-3 instance
    task automatic reset_on_wrap();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 4 * HT * VT * DA && !found; n++) begin
            if (wraps_at(ka + 1, DA)) found = 1'b1;
            else run(1);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL wrap_align: got no wrap within bound, required one");
        end else begin
            syncs++;
        end
        pulse_reset(1 + $urandom_range(0, 3));
    endtask

    initial begin
        resetN = 1'b0;
        run(4);
        resetN = 1'b1;
        run(3 * HT * VT * DA + 50);
        reset_on_wrap();
        run(2 * HT * VT * DA);
        for (int i = 0; i < 16; i++) begin
            run($urandom_range(1, 2500));
            if ($urandom_range(0, 2) == 0) reset_on_wrap();
            else pulse_reset($urandom_range(1, 6));
        end
        run(HT * VT * DA + 10);
        resetN = 1'b0;
        run(1);
        resetN = 1'b1;
        run(50);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (qa.size() > 1 || qb.size() > 1) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending, required <=1",
                     qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
